// File: rtl/fifo_burst_drain_if.sv
// fifo_burst_drain_if
//   Bundles the FIFO read port and the downstream burst handshake of the
//   camera-FIFO drain controller.
//   master : the drain controller (drives r_en, burst_req/single, out_*).
//   slave  : the environment (FIFO read side plus the SDRAM writer).
//   Signals:
//     r_empty, r_almost_empty, r_data  FIFO status and read data
//     r_en                             FIFO read enable
//     burst_req, burst_single          burst request and its length select
//     burst_gnt                        downstream grant
//     out_valid, out_data, burst_done  word stream to the memory writer
interface fifo_burst_drain_if #(
  parameter int DATA_SIZE = 16
);
  logic                 r_empty;
  logic                 r_almost_empty;
  logic [DATA_SIZE-1:0] r_data;
  logic                 r_en;
  logic                 burst_req;
  logic                 burst_single;
  logic                 burst_gnt;
  logic                 out_valid;
  logic [DATA_SIZE-1:0] out_data;
  logic                 burst_done;

  modport master (
    input  r_empty, r_almost_empty, r_data, burst_gnt,
    output r_en, burst_req, burst_single, out_valid, out_data, burst_done
  );

  modport slave (
    output r_empty, r_almost_empty, r_data, burst_gnt,
    input  r_en, burst_req, burst_single, out_valid, out_data, burst_done
  );
endinterface

// File: rtl/fifo_burst_drain.sv
// fifo_burst_drain
//   Read-side controller for the camera pixel async FIFO (read clock domain
//   only). Pulls BURST_LEN-word bursts whenever the FIFO is not almost
//   empty, or single-word bursts while flush is high, and hands each burst
//   to the memory writer through a req/gnt handshake.
//   Ports:
//     r_clk, r_rst   clock, synchronous active-high reset
//     flush          level; lets IDLE start 1-word bursts below threshold
//     bus            FIFO + downstream handshake (master side)
//     burst_count    completed bursts, wraps
//     underrun_err   sticky: a read was issued while the FIFO was empty
module fifo_burst_drain #(
  parameter int DATA_SIZE = 16,
  parameter int BURST_LEN = 4,
  parameter int CNT_SIZE  = 16
) (
  input  logic                r_clk,
  input  logic                r_rst,
  input  logic                flush,
  fifo_burst_drain_if.master  bus,
  output logic [CNT_SIZE-1:0] burst_count,
  output logic                underrun_err
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] READ = 2'd2;
  localparam logic [1:0] TAIL = 2'd3;

  localparam logic [5:0] LAST_FULL = 6'(BURST_LEN - 1);

  logic [1:0] state;
  logic       single_q;
  logic [5:0] cnt;
  logic       fire_q;
  logic [5:0] last_idx;

  assign last_idx = single_q ? 6'd0 : LAST_FULL;

  assign bus.r_en         = (state == READ);
  assign bus.burst_req    = (state == REQ);
  assign bus.burst_single = single_q;
  assign bus.burst_done   = (state == TAIL);
  assign bus.out_valid    = fire_q;
  // r_data is the FIFO's registered read port, valid the cycle after the
  // read; pass it through only in slots whose read actually fired so that
  // underrun and idle slots show zero.
  assign bus.out_data     = fire_q ? bus.r_data : {DATA_SIZE{1'b0}};

  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      state        <= IDLE;
      single_q     <= 1'b0;
      cnt          <= 6'd0;
      fire_q       <= 1'b0;
      burst_count  <= '0;
      underrun_err <= 1'b0;
    end else begin
      fire_q <= bus.r_en & ~bus.r_empty;
      if (bus.r_en & bus.r_empty)
        underrun_err <= 1'b1;

      case (state)
        // Always at least one cycle here so the FIFO flags settle after a
        // burst before they are trusted again.
        IDLE: begin
          if (!bus.r_empty && !bus.r_almost_empty) begin
            single_q <= 1'b0;
            state    <= REQ;
          end else if (!bus.r_empty && flush) begin
            single_q <= 1'b1;
            state    <= REQ;
          end
        end
        REQ: begin
          if (bus.burst_gnt) begin
            cnt   <= 6'd0;
            state <= READ;
          end
        end
        // The counter advances even on underrun slots so the burst length
        // in cycles never changes.
        READ: begin
          cnt <= cnt + 6'd1;
          if (cnt == last_idx)
            state <= TAIL;
        end
        TAIL: begin
          burst_count <= burst_count + 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_burst_drain.sv
module tb_fifo_burst_drain;
  localparam int DW = 16;
  localparam int BL = 4;
  localparam int CW = 16;

  logic          r_clk = 1'b0;
  logic          r_rst = 1'b1;
  logic          flush = 1'b0;
  logic [CW-1:0] burst_count;
  logic          underrun_err;

  fifo_burst_drain_if #(.DATA_SIZE(DW)) bus ();

  fifo_burst_drain #(.DATA_SIZE(DW), .BURST_LEN(BL), .CNT_SIZE(CW)) dut (
    .r_clk       (r_clk),
    .r_rst       (r_rst),
    .flush       (flush),
    .bus         (bus),
    .burst_count (burst_count),
    .underrun_err(underrun_err)
  );

  always #5 r_clk = ~r_clk;

  // FIFO model: registered read port, data valid the cycle after a read.
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  logic          r_empty_m = 1'b1;
  logic          force_e   = 1'b0;
  logic          ae        = 1'b1;
  logic          gnt       = 1'b0;
  logic [DW-1:0] r_data_m  = '0;

  assign bus.r_empty        = r_empty_m | force_e;
  assign bus.r_almost_empty = ae;
  assign bus.r_data         = r_data_m;
  assign bus.burst_gnt      = gnt;

  always @(posedge r_clk) begin
    if (bus.r_en && !bus.r_empty && fifo_q.size() > 0)
      r_data_m <= fifo_q.pop_front();
    r_empty_m <= (fifo_q.size() == 0);
  end

  int errors = 0;
  int checks = 0;
  int ren_cnt, req_cnt, sgl_cnt, valid_cnt, done_cnt;

  // Scoreboard monitor: every valid word must match the next expected word.
  always @(negedge r_clk) begin
    if (!r_rst) begin
      if (bus.r_en) ren_cnt++;
      if (bus.burst_req) begin
        req_cnt++;
        if (bus.burst_single) sgl_cnt++;
      end
      if (bus.burst_done) done_cnt++;
      if (bus.out_valid) begin
        valid_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got out_data=%h, no word expected", bus.out_data);
        end else begin
          logic [DW-1:0] e;
          e = exp_q.pop_front();
          if (bus.out_data !== e) begin
            errors++;
            $display("FAIL sb_data: got %h exp %h", bus.out_data, e);
          end
        end
      end
    end
  end

  task automatic tick;
    @(negedge r_clk);
    #1;
  endtask

  task automatic clear_counters;
    ren_cnt = 0; req_cnt = 0; sgl_cnt = 0; valid_cnt = 0; done_cnt = 0;
  endtask

  task automatic do_reset;
    r_rst = 1'b1; gnt = 1'b0; flush = 1'b0; ae = 1'b1; force_e = 1'b0;
    tick;
    fifo_q.delete(); exp_q.delete();
    tick;
    r_rst = 1'b0;
    tick;
    clear_counters;
  endtask

  task automatic test_reset;
    r_rst = 1'b1; gnt = 1'b0; flush = 1'b0; ae = 1'b1; force_e = 1'b0;
    fifo_q.delete(); exp_q.delete();
    repeat (3) tick;
    checks++;
    if ({bus.r_en, bus.burst_req, bus.burst_single, bus.out_valid, bus.burst_done, underrun_err} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b exp 000000",
               {bus.r_en, bus.burst_req, bus.burst_single, bus.out_valid, bus.burst_done, underrun_err});
    end
    checks++;
    if (bus.out_data !== '0) begin errors++; $display("FAIL reset_data: got %h exp 0", bus.out_data); end
    checks++;
    if (burst_count !== '0) begin errors++; $display("FAIL reset_count: got %0d exp 0", burst_count); end
    r_rst = 1'b0;
    repeat (2) tick;
    checks++;
    if (bus.burst_req !== 1'b0) begin errors++; $display("FAIL reset_idle: got req=%b exp 0", bus.burst_req); end
    clear_counters;
  endtask

  task automatic test_full_burst;
    int n;
    clear_counters;
    for (int i = 1; i <= 8; i++) begin
      fifo_q.push_back(DW'(i)); exp_q.push_back(DW'(i));
    end
    ae = 1'b0; gnt = 1'b0;
    n = 0;
    while (!bus.burst_req && n < 20) begin tick; n++; end
    checks++;
    if (bus.burst_req !== 1'b1) begin errors++; $display("FAIL full_req_timeout: got req=%b exp 1", bus.burst_req); end
    checks++;
    if (bus.burst_single !== 1'b0) begin errors++; $display("FAIL full_single: got %b exp 0", bus.burst_single); end
    repeat (3) tick;
    checks++;
    if (bus.burst_req !== 1'b1 || ren_cnt != 0) begin
      errors++; $display("FAIL full_wait_gnt: got req=%b ren=%0d exp req=1 ren=0", bus.burst_req, ren_cnt);
    end
    gnt = 1'b1;
    tick;
    gnt = 1'b0;
    checks++;
    if (bus.burst_req !== 1'b0 || bus.r_en !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL full_read1: got req=%b ren=%b vld=%b exp 0 1 0", bus.burst_req, bus.r_en, bus.out_valid);
    end
    tick;
    checks++;
    if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL full_latency: got vld=%b exp 1", bus.out_valid); end
    n = 0;
    while (!bus.burst_done && n < 10) begin tick; n++; end
    checks++;
    if (bus.burst_done !== 1'b1 || bus.out_valid !== 1'b1 || bus.out_data !== 16'h0004) begin
      errors++; $display("FAIL full_done: got done=%b vld=%b data=%h exp 1 1 0004", bus.burst_done, bus.out_valid, bus.out_data);
    end
    tick;
    checks++;
    if (burst_count !== 16'd1 || ren_cnt != 4 || valid_cnt != 4) begin
      errors++; $display("FAIL full_first: got cnt=%0d ren=%0d vld=%0d exp 1 4 4", burst_count, ren_cnt, valid_cnt);
    end
    gnt = 1'b1;
    n = 0;
    while (done_cnt < 2 && n < 30) begin tick; n++; end
    gnt = 1'b0;
    tick;
    checks++;
    if (burst_count !== 16'd2 || ren_cnt != 8 || sgl_cnt != 0 || exp_q.size() != 0) begin
      errors++; $display("FAIL full_second: got cnt=%0d ren=%0d sgl=%0d left=%0d exp 2 8 0 0",
                         burst_count, ren_cnt, sgl_cnt, exp_q.size());
    end
    ae = 1'b1;
  endtask

  task automatic test_residue;
    do_reset;
    fifo_q.push_back(16'h00AA); fifo_q.push_back(16'h00BB);
    ae = 1'b1; flush = 1'b0; gnt = 1'b1;
    repeat (20) tick;
    checks++;
    if (req_cnt != 0 || ren_cnt != 0) begin
      errors++; $display("FAIL residue_idle: got req=%0d ren=%0d exp 0 0", req_cnt, ren_cnt);
    end
  endtask

  task automatic test_flush;
    int n;
    exp_q.push_back(16'h00AA); exp_q.push_back(16'h00BB);
    flush = 1'b1;
    n = 0;
    while (done_cnt < 2 && n < 40) begin tick; n++; end
    tick;
    checks++;
    if (burst_count !== 16'd2 || ren_cnt != 2 || req_cnt != 2 || sgl_cnt != 2) begin
      errors++; $display("FAIL flush_bursts: got cnt=%0d ren=%0d req=%0d sgl=%0d exp 2 2 2 2",
                         burst_count, ren_cnt, req_cnt, sgl_cnt);
    end
    checks++;
    if (valid_cnt != 2 || exp_q.size() != 0) begin
      errors++; $display("FAIL flush_words: got vld=%0d left=%0d exp 2 0", valid_cnt, exp_q.size());
    end
    repeat (10) tick;
    checks++;
    if (bus.r_en !== 1'b0 || bus.burst_req !== 1'b0 || ren_cnt != 2) begin
      errors++; $display("FAIL flush_empty_idle: got ren=%b req=%b rcnt=%0d exp 0 0 2", bus.r_en, bus.burst_req, ren_cnt);
    end
    flush = 1'b0; gnt = 1'b0;
  endtask

  task automatic test_stall_reset;
    int n;
    do_reset;
    for (int i = 0; i < 8; i++) fifo_q.push_back(DW'(16'h0010 + i));
    exp_q.push_back(16'h0010); exp_q.push_back(16'h0011);
    ae = 1'b0; gnt = 1'b0;
    n = 0;
    while (!bus.burst_req && n < 20) begin tick; n++; end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (bus.burst_req !== 1'b1 || bus.r_en !== 1'b0) begin
        errors++; $display("FAIL stall_cycle%0d: got req=%b ren=%b exp 1 0", i, bus.burst_req, bus.r_en);
      end
      tick;
    end
    gnt = 1'b1;
    tick;
    gnt = 1'b0;
    n = 0;
    while (valid_cnt < 2 && n < 10) begin tick; n++; end
    ae = 1'b1;
    r_rst = 1'b1;
    tick;
    checks++;
    if ({bus.r_en, bus.burst_req, bus.burst_single, bus.out_valid, bus.burst_done} !== 5'b0 ||
        bus.out_data !== '0 || burst_count !== '0) begin
      errors++; $display("FAIL midreset_outs: got ctl=%b data=%h cnt=%0d exp 0 0 0",
                         {bus.r_en, bus.burst_req, bus.burst_single, bus.out_valid, bus.burst_done},
                         bus.out_data, burst_count);
    end
    r_rst = 1'b0;
    repeat (5) tick;
    checks++;
    if (valid_cnt != 2 || exp_q.size() != 0) begin
      errors++; $display("FAIL midreset_discard: got vld=%0d left=%0d exp 2 0", valid_cnt, exp_q.size());
    end
    fifo_q.delete();
  endtask

  task automatic test_underrun;
    int n;
    do_reset;
    for (int i = 0; i < 4; i++) fifo_q.push_back(DW'(16'h0021 + i));
    exp_q.push_back(16'h0021); exp_q.push_back(16'h0022); exp_q.push_back(16'h0023);
    ae = 1'b0; gnt = 1'b1;
    n = 0;
    while (!bus.r_en && n < 20) begin tick; n++; end
    checks++;
    if (bus.r_en !== 1'b1) begin errors++; $display("FAIL under_read_timeout: got ren=%b exp 1", bus.r_en); end
    ae = 1'b1; gnt = 1'b0;
    tick;
    tick;
    force_e = 1'b1;
    tick;
    force_e = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.r_en !== 1'b1) begin
      errors++; $display("FAIL under_slot: got vld=%b ren=%b exp 0 1", bus.out_valid, bus.r_en);
    end
    tick;
    checks++;
    if (bus.burst_done !== 1'b1 || bus.out_valid !== 1'b1 || bus.out_data !== 16'h0023) begin
      errors++; $display("FAIL under_done: got done=%b vld=%b data=%h exp 1 1 0023", bus.burst_done, bus.out_valid, bus.out_data);
    end
    tick;
    checks++;
    if (burst_count !== 16'd1 || valid_cnt != 3 || ren_cnt != 4 || underrun_err !== 1'b1) begin
      errors++; $display("FAIL under_summary: got cnt=%0d vld=%0d ren=%0d err=%b exp 1 3 4 1",
                         burst_count, valid_cnt, ren_cnt, underrun_err);
    end
    repeat (10) tick;
    checks++;
    if (underrun_err !== 1'b1) begin errors++; $display("FAIL under_sticky: got %b exp 1", underrun_err); end
    r_rst = 1'b1;
    tick;
    checks++;
    if (underrun_err !== 1'b0) begin errors++; $display("FAIL under_clear: got %b exp 0", underrun_err); end
    fifo_q.delete(); exp_q.delete();
    r_rst = 1'b0;
    tick;
  endtask

  initial begin
    clear_counters;
    test_reset;
    test_full_burst;
    test_residue;
    test_flush;
    test_stall_reset;
    test_underrun;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fifo_burst_drain.md
Name: fifo_burst_drain

Overview:
- Read-side controller for the camera pixel async FIFO; runs entirely in the FIFO read clock domain.
- Watches the FIFO's r_empty and r_almost_empty flags and pulls data out in fixed-length bursts via r_en.
- Hands each burst to the downstream memory writer (SDRAM path) through a request/grant handshake.
- A flush input drains the residue left below the almost-empty threshold at end of frame, one single-word burst at a time.

Parameters:
- DATA_SIZE, 16: width of FIFO data and of out_data.
- BURST_LEN, 4: words per normal burst. Legal range 1..63. Must be strictly less than the FIFO's ALMOST_EMPTY_FLAG_POS.
- CNT_SIZE, 16: width of the burst_count counter.

Ports:
- r_clk  in  1  read-domain clock; sole clock of the block.
- r_rst  in  1  synchronous, active-high reset.
- r_empty  in  1  FIFO empty flag.
- r_almost_empty  in  1  FIFO almost-empty flag. 0 guarantees at least BURST_LEN words are available.
- r_data  in  DATA_SIZE  FIFO read data; valid 1 cycle after an accepted r_en.
- r_en  out  1  FIFO read enable.
- flush  in  1  level input; permits single-word bursts while the FIFO is almost empty.
- burst_req  out  1  burst request to downstream.
- burst_single  out  1  qualifies burst_req: 1 = 1-word burst, 0 = BURST_LEN words.
- burst_gnt  in  1  downstream grant; sampled only while burst_req=1.
- out_valid  out  1  out_data valid this cycle. Downstream cannot stall.
- out_data  out  DATA_SIZE  registered copy of r_data.
- burst_done  out  1  1-cycle pulse on the last word of a burst.
- burst_count  out  CNT_SIZE  completed bursts; wraps modulo 2^CNT_SIZE.
- underrun_err  out  1  sticky error flag.

Behaviour:
- Reset: synchronous, active-high; takes effect at any state including mid-burst. In-flight words are discarded and are not presented later.
  - Outputs: r_en=0, burst_req=0, burst_single=0, out_valid=0, out_data=0, burst_done=0, burst_count=0, underrun_err=0.
  - State returns to IDLE.
- States: IDLE, REQ, READ, TAIL.
- IDLE: minimum stay of 1 cycle, which absorbs the FIFO flag update latency after a burst. Evaluated in priority order:
  - r_empty=0 and r_almost_empty=0 -> REQ with burst_single=0.
  - else r_empty=0 and flush=1 -> REQ with burst_single=1.
  - else remain in IDLE.
- REQ:
  - burst_req=1; burst_single held constant.
  - No timeout: burst_req stays high until burst_gnt=1 is sampled.
  - On the edge where burst_gnt=1 is sampled -> READ. burst_req drops in the same edge.
- READ:
  - r_en=1 for exactly N consecutive cycles, where N = 1 if burst_single else BURST_LEN.
  - Counted by an internal 6-bit counter; after the Nth cycle -> TAIL.
- TAIL:
  - r_en=0; presents the last word.
  - -> IDLE next cycle.
- Data path:
  - Each READ cycle at t registers fire = r_en & !r_empty.
  - At t+1: out_valid = fire, and out_data = r_data captured at t+1.
  - Words therefore appear on N consecutive cycles, from the cycle after the first READ cycle through TAIL.
  - Latency: burst_gnt sampled at edge k -> first out_valid in cycle k+2; last out_valid in cycle k+1+N.
- burst_done:
  - Asserted together with the out_valid of TAIL.
  - If that word was lost to underrun, burst_done is still asserted in TAIL.
  - burst_count increments by 1 on the same edge.
- Underrun:
  - Triggered when r_en=1 while r_empty=1 in READ.
  - That slot gets out_valid=0; the counter still advances, so the burst length in cycles is unchanged.
  - underrun_err is set to 1 and holds until r_rst.
- flush:
  - Affects only the IDLE decision; changes in REQ, READ or TAIL are ignored.
  - flush=1 with r_almost_empty=0 still starts full bursts.
- Simultaneous events:
  - burst_gnt=1 outside REQ is ignored.
  - r_rst=1 dominates every other input.

Test Plan:
- Reset: hold r_rst 3 cycles in any state -> all outputs 0, burst_count=0, state IDLE.
- Full burst (BURST_LEN=4):
  - Stimulus: FIFO model preloaded with 0x0001..0x0008, r_almost_empty=0; burst_gnt raised 3 cycles after burst_req.
  - Required: burst_single=0; r_en high 4 cycles; out_data 0x0001,0x0002,0x0003,0x0004 on 4 consecutive out_valid cycles; burst_done with 0x0004; burst_count=1.
  - Then a second burst yields 0x0005..0x0008 and burst_count=2.
- Residue without flush: 2 words, r_almost_empty=1, flush=0 for 20 cycles -> burst_req never asserted, r_en never asserted.
- Flush drain: same 2 words (0x00AA, 0x00BB), flush=1, burst_gnt tied high -> two bursts with burst_single=1, each with 1 r_en cycle; out_data 0x00AA then 0x00BB; burst_count=2; then IDLE once r_empty=1.
- Grant stall then mid-burst reset:
  - burst_gnt held low 10 cycles -> burst_req high all 10 cycles, r_en stays 0.
  - Then grant; assert r_rst after 2 words are out -> next cycle all outputs 0, no further out_valid, burst_count=0.
- Underrun: force r_empty=1 in the 3rd READ cycle of a 4-word burst -> that slot's out_valid=0; 3 valid words delivered; burst_done still pulses; underrun_err=1 and remains 1 until r_rst.
